// File: rtl/corner_locator.sv
// Marker-colour corner locator: raster-scans an RGB frame, tracks the four extreme marker
// pixels and publishes them at end of frame. Define CORNER_HOLD_EN to keep corners on a failed frame.
module corner_locator #(
    parameter int         H_ACTIVE  = 800,
    parameter int         V_ACTIVE  = 600,
    parameter logic [9:0] R_MIN     = 10'd600,
    parameter logic [9:0] G_MAX     = 10'd300,
    parameter logic [9:0] B_MAX     = 10'd300,
    parameter int         MIN_COUNT = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_data,
    input  logic        i_resync,
    output logic        o_addr_valid,
    output logic [19:0] o_ul_addr,
    output logic [19:0] o_ur_addr,
    output logic [19:0] o_dl_addr,
    output logic [19:0] o_dr_addr,
    output logic        o_enable,
    output logic [18:0] o_count
);

    localparam logic [9:0]  COL_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  ROW_LAST = 10'(V_ACTIVE - 1);
    localparam logic [10:0] A_OFS    = 11'(V_ACTIVE);
    localparam logic [10:0] B_OFS    = 11'(H_ACTIVE);
    localparam logic [18:0] CNT_MAX  = '1;
    localparam logic [18:0] MIN_CNT  = 19'(MIN_COUNT);
    localparam logic [10:0] UL_CLR   = 11'h7FF;

    logic [9:0]  row;
    logic [9:0]  col;
    logic        accept;
    logic        col_last;
    logic        row_last;
    logic        eof;

    logic [9:0]  px_r;
    logic [9:0]  px_g;
    logic [9:0]  px_b;
    logic        unused_pad;
    logic        marker;

    logic [10:0] s_m;
    logic [10:0] a_m;
    logic [10:0] b_m;
    logic [19:0] pix_addr;

    logic [10:0] ul_m, ur_m, dl_m, dr_m;
    logic [19:0] ul_a, ur_a, dl_a, dr_a;
    logic        seen;
    logic [18:0] count;

    logic [10:0] ul_m_nxt, ur_m_nxt, dl_m_nxt, dr_m_nxt;
    logic [19:0] ul_a_nxt, ur_a_nxt, dl_a_nxt, dr_a_nxt;
    logic        seen_nxt;
    logic [18:0] count_nxt;
    logic        enable_nxt;

    assign accept   = i_valid && !i_resync;
    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    assign eof      = accept && col_last && row_last;

    assign px_r       = i_data[29:20];
    assign px_g       = i_data[19:10];
    assign px_b       = i_data[9:0];
    assign unused_pad = ^i_data[31:30];
    assign marker     = accept && (px_r >= R_MIN) && (px_g <= G_MAX) && (px_b <= B_MAX);

    // Offsets keep a and b non-negative so all metrics compare as plain unsigned values.
    assign s_m      = {1'b0, row} + {1'b0, col};
    assign a_m      = {1'b0, col} + A_OFS - {1'b0, row};
    assign b_m      = {1'b0, row} + B_OFS - {1'b0, col};
    assign pix_addr = {row, col};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            row <= '0;
            col <= '0;
        end else if (i_resync) begin
            row <= '0;
            col <= '0;
        end else if (i_valid) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 10'd1;
            end else begin
                col <= col + 10'd1;
            end
        end
    end

    // Next tracker state including the current pixel; the snapshot reads these so the
    // final pixel of the frame is reported without an extra pipeline stage.
    always_comb begin
        ul_m_nxt  = ul_m;
        ur_m_nxt  = ur_m;
        dl_m_nxt  = dl_m;
        dr_m_nxt  = dr_m;
        ul_a_nxt  = ul_a;
        ur_a_nxt  = ur_a;
        dl_a_nxt  = dl_a;
        dr_a_nxt  = dr_a;
        seen_nxt  = seen;
        count_nxt = count;
        if (marker) begin
            seen_nxt = 1'b1;
            if (count != CNT_MAX) begin
                count_nxt = count + 19'd1;
            end
            if (!seen) begin
                ul_m_nxt = s_m;
                dr_m_nxt = s_m;
                ur_m_nxt = a_m;
                dl_m_nxt = b_m;
                ul_a_nxt = pix_addr;
                ur_a_nxt = pix_addr;
                dl_a_nxt = pix_addr;
                dr_a_nxt = pix_addr;
            end else begin
                if (s_m < ul_m) begin
                    ul_m_nxt = s_m;
                    ul_a_nxt = pix_addr;
                end
                if (s_m > dr_m) begin
                    dr_m_nxt = s_m;
                    dr_a_nxt = pix_addr;
                end
                if (a_m > ur_m) begin
                    ur_m_nxt = a_m;
                    ur_a_nxt = pix_addr;
                end
                if (b_m > dl_m) begin
                    dl_m_nxt = b_m;
                    dl_a_nxt = pix_addr;
                end
            end
        end
    end

    assign enable_nxt = (count_nxt >= MIN_CNT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ul_m  <= UL_CLR;
            ur_m  <= '0;
            dl_m  <= '0;
            dr_m  <= '0;
            ul_a  <= '0;
            ur_a  <= '0;
            dl_a  <= '0;
            dr_a  <= '0;
            seen  <= 1'b0;
            count <= '0;
        end else if (i_resync || eof) begin
            ul_m  <= UL_CLR;
            ur_m  <= '0;
            dl_m  <= '0;
            dr_m  <= '0;
            ul_a  <= '0;
            ur_a  <= '0;
            dl_a  <= '0;
            dr_a  <= '0;
            seen  <= 1'b0;
            count <= '0;
        end else begin
            ul_m  <= ul_m_nxt;
            ur_m  <= ur_m_nxt;
            dl_m  <= dl_m_nxt;
            dr_m  <= dr_m_nxt;
            ul_a  <= ul_a_nxt;
            ur_a  <= ur_a_nxt;
            dl_a  <= dl_a_nxt;
            dr_a  <= dr_a_nxt;
            seen  <= seen_nxt;
            count <= count_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_addr_valid <= 1'b0;
            o_ul_addr    <= '0;
            o_ur_addr    <= '0;
            o_dl_addr    <= '0;
            o_dr_addr    <= '0;
            o_enable     <= 1'b0;
            o_count      <= '0;
        end else begin
            o_addr_valid <= eof;
            if (eof) begin
                o_count  <= count_nxt;
                o_enable <= enable_nxt;
                if (enable_nxt) begin
                    o_ul_addr <= ul_a_nxt;
                    o_ur_addr <= ur_a_nxt;
                    o_dl_addr <= dl_a_nxt;
                    o_dr_addr <= dr_a_nxt;
                end else begin
`ifdef CORNER_HOLD_EN
                    o_ul_addr <= o_ul_addr;
                    o_ur_addr <= o_ur_addr;
                    o_dl_addr <= o_dl_addr;
                    o_dr_addr <= o_dr_addr;
`else
                    o_ul_addr <= '0;
                    o_ur_addr <= '0;
                    o_dl_addr <= '0;
                    o_dr_addr <= '0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_corner_locator.sv
// Directed bench for corner_locator on a reduced 64x48 frame; two instances cover MIN_COUNT 64 and 1.
module tb_corner_locator;

    localparam int H = 64;
    localparam int V = 48;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        resync = 1'b0;
    logic [31:0] data = '0;

    logic        av0, en0, av1, en1;
    logic [19:0] ul0, ur0, dl0, dr0, ul1, ur1, dl1, dr1;
    logic [18:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;
    int pulses0 = 0;
    int pulses1 = 0;

    always #5 clk = ~clk;

    corner_locator #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_COUNT(64)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data), .i_resync(resync),
        .o_addr_valid(av0), .o_ul_addr(ul0), .o_ur_addr(ur0), .o_dl_addr(dl0),
        .o_dr_addr(dr0), .o_enable(en0), .o_count(cnt0)
    );

    corner_locator #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_COUNT(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data), .i_resync(resync),
        .o_addr_valid(av1), .o_ul_addr(ul1), .o_ur_addr(ur1), .o_dl_addr(dl1),
        .o_dr_addr(dr1), .o_enable(en1), .o_count(cnt1)
    );

    always @(posedge clk) begin
        if (av0) pulses0++;
        if (av1) pulses1++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] addr(input int r, input int c);
        return {r[9:0], c[9:0]};
    endfunction

    function automatic logic [31:0] pix(input int mode, input int r, input int c);
        logic [31:0] mk;
        mk = {2'b00, 10'd1023, 10'd0, 10'd0};
        case (mode)
            0: return (r >= 10 && r <= 25 && c >= 20 && c <= 35) ? mk : 32'h0;
            2: return (r == 0 && c == 0) ? mk : 32'h0;
            3: return ((r == 0 && c == H-1) || (r == V-1 && c == 0)) ? mk : 32'h0;
            4: return ((r == 0 && c == 5) || (r == 5 && c == 0)) ? mk : 32'h0;
            5: begin
                if (r == 3 && c == 3) return {2'b00, 10'd600, 10'd300, 10'd300};
                if (r == 4 && c == 4) return {2'b00, 10'd599, 10'd0, 10'd0};
                if (r == 5 && c == 5) return {2'b00, 10'd1023, 10'd301, 10'd0};
                if (r == 6 && c == 6) return {2'b00, 10'd1023, 10'd0, 10'd301};
                return 32'h0;
            end
            6: return (r == 40 && c == 40) ? mk : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic send(input logic v, input logic [31:0] d);
        valid = v;
        data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic run_rows(input int mode, input int r0, input int r1, input bit gaps);
        for (int r = r0; r <= r1; r++) begin
            for (int c = 0; c < H; c++) begin
                if (gaps) begin
                    if ($urandom_range(0, 1) == 1) send(1'b0, 32'h0);
                end
                send(1'b1, pix(mode, r, c));
            end
        end
    endtask

    task automatic expect_frame(input string tag, input int which, input int p_start,
                                input logic [19:0] eul, input logic [19:0] eur,
                                input logic [19:0] edl, input logic [19:0] edr,
                                input logic een, input logic [18:0] ecnt);
        valid = 1'b0;
        data  = '0;
        @(negedge clk);
        chk({tag, ".pulse"}, which ? av1 : av0, 1);
        chk({tag, ".ul"}, which ? ul1 : ul0, eul);
        chk({tag, ".ur"}, which ? ur1 : ur0, eur);
        chk({tag, ".dl"}, which ? dl1 : dl0, edl);
        chk({tag, ".dr"}, which ? dr1 : dr0, edr);
        chk({tag, ".enable"}, which ? en1 : en0, een);
        chk({tag, ".count"}, which ? cnt1 : cnt0, ecnt);
        @(negedge clk);
        chk({tag, ".pulse_end"}, which ? av1 : av0, 0);
        chk({tag, ".npulses"}, (which ? pulses1 : pulses0) - p_start, 1);
    endtask

    logic [19:0] b_ul, b_ur, b_dl, b_dr;
    int p;

    initial begin
        b_ul = addr(10, 20);
        b_ur = addr(10, 35);
        b_dl = addr(25, 20);
        b_dr = addr(25, 35);

        #2;
        chk("rst.pulse", av0, 0);
        chk("rst.ul", ul0, 0);
        chk("rst.enable", en0, 0);
        chk("rst.count", cnt0, 0);
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;

        p = pulses0;
        run_rows(0, 0, V-1, 0);
        expect_frame("block", 0, p, b_ul, b_ur, b_dl, b_dr, 1'b1, 19'd256);

        p = pulses0;
        run_rows(1, 0, V-1, 0);
`ifdef CORNER_HOLD_EN
        expect_frame("black", 0, p, b_ul, b_ur, b_dl, b_dr, 1'b0, 19'd0);
`else
        expect_frame("black", 0, p, 20'd0, 20'd0, 20'd0, 20'd0, 1'b0, 19'd0);
`endif

        p = pulses1;
        run_rows(2, 0, V-1, 0);
        expect_frame("single", 1, p, addr(0, 0), addr(0, 0), addr(0, 0), addr(0, 0), 1'b1, 19'd1);

        p = pulses1;
        run_rows(3, 0, V-1, 0);
        expect_frame("corners", 1, p, addr(V-1, 0), addr(0, H-1), addr(V-1, 0), addr(0, H-1),
                     1'b1, 19'd2);

        p = pulses1;
        run_rows(4, 0, V-1, 0);
        expect_frame("tie", 1, p, addr(0, 5), addr(0, 5), addr(5, 0), addr(0, 5), 1'b1, 19'd2);

        p = pulses1;
        run_rows(5, 0, V-1, 0);
        expect_frame("thresh", 1, p, addr(3, 3), addr(3, 3), addr(3, 3), addr(3, 3), 1'b1, 19'd1);

        p = pulses0;
        run_rows(0, 0, V-1, 1);
        expect_frame("gaps", 0, p, b_ul, b_ur, b_dl, b_dr, 1'b1, 19'd256);

        // Partial frame, then resync with a discarded marker pixel, then a fresh frame.
        p = pulses1;
        run_rows(0, 0, 29, 0);
        resync = 1'b1;
        send(1'b1, {2'b00, 10'd1023, 10'd0, 10'd0});
        resync = 1'b0;
        run_rows(6, 0, V-1, 0);
        expect_frame("resync", 1, p, addr(40, 40), addr(40, 40), addr(40, 40), addr(40, 40),
                     1'b1, 19'd1);

        run_rows(0, 0, 20, 0);
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst.ul1", ul1, 0);
        chk("midrst.count1", cnt1, 0);
        chk("midrst.enable1", en1, 0);
        chk("midrst.ul0", ul0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        p = pulses0;
        run_rows(0, 0, V-1, 0);
        expect_frame("postrst", 0, p, b_ul, b_ur, b_dl, b_dr, 1'b1, 19'd256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
